// File: rtl/iss_memory_responder.sv
// iss_memory_responder
// Memory-side responder for the ISS core's instruction/data memory port.
// Accepts fetch/load/store requests over a notify/sync handshake, holds a
// word-organised little-endian RAM with byte/half/word access, and returns
// sign/zero-extended load data over a second notify/sync handshake after a
// configurable number of read wait states.  One request is outstanding at
// a time.
//
// Ports
//   clk              clock, all state on rising edge
//   rst              asynchronous, active-low reset
//   req_addrin       request byte address (upper bits alias modulo MEM_WORDS*4)
//   req_datain       store data (byte/half taken from the low bits)
//   req_mask         access size: 0=mt_b 1=mt_bu 2=mt_h 3=mt_hu 4=mt_w
//                    (5..7 behave as mt_w)
//   req_req          access type: 0=me_rd 1=me_wr
//   req_notify       core presents a valid request
//   req_sync         responder ready; transfer on req_notify && req_sync
//   resp_loadeddata  load result, stable while resp_sync is high
//   resp_notify      core is waiting for read data
//   resp_sync        read data valid; transfer on resp_notify && resp_sync
//   misalign_err     sticky flag: a misaligned access was accepted since reset

module iss_memory_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addrin,
  input  logic [31:0] req_datain,
  input  logic [2:0]  req_mask,
  input  logic        req_req,
  input  logic        req_notify,
  output logic        req_sync,
  output logic [31:0] resp_loadeddata,
  input  logic        resp_notify,
  output logic        resp_sync,
  output logic        misalign_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_BU = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_HU = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   mem [MEM_WORDS];

  logic [3:0]    wait_cnt;
  logic [AW-1:0] cap_word;
  logic [1:0]    cap_lane;
  logic [2:0]    cap_mask;
  logic          cap_misaligned;

  logic          accept;
  logic [AW-1:0] req_word;
  logic [1:0]    req_lane;
  logic          req_is_byte;
  logic          req_is_half;
  logic          req_misaligned;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_value;

  // Address bits above the RAM range are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addrin[31:AW+2]};

  // Request decode.  Accept only depends on the state, so req_sync never
  // feeds back into its own condition.
  assign accept         = req_notify && (state == IDLE);
  assign req_word       = req_addrin[AW+1:2];
  assign req_lane       = req_addrin[1:0];
  assign req_is_byte    = (req_mask == MT_B) || (req_mask == MT_BU);
  assign req_is_half    = (req_mask == MT_H) || (req_mask == MT_HU);
  assign req_misaligned = req_is_half ? req_lane[0] :
                          (!req_is_byte && (req_lane != 2'd0));

  // Store lane enables and lane-replicated store data; misaligned stores
  // are dropped by never raising wr_en.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = req_datain;
    if (req_is_byte) begin
      wr_be   = 4'b0001 << req_lane;
      wr_data = {4{req_datain[7:0]}};
    end else if (req_is_half) begin
      wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{req_datain[15:0]}};
    end
  end

  assign wr_en = accept && req_req && !req_misaligned;

  // RAM write port.  Contents are deliberately not reset so a preloaded
  // image survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[req_word][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Load formatting from the captured address: lane select, then sign or
  // zero extension.  A misaligned load returns zero.
  assign rd_word = mem[cap_word];
  assign rd_byte = 8'(rd_word >> {cap_lane, 3'b000});
  assign rd_half = cap_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_value = rd_word;
    case (cap_mask)
      MT_B:    load_value = {{24{rd_byte[7]}}, rd_byte};
      MT_BU:   load_value = {24'd0, rd_byte};
      MT_H:    load_value = {{16{rd_half[15]}}, rd_half};
      MT_HU:   load_value = {16'd0, rd_half};
      default: load_value = rd_word;
    endcase
    if (cap_misaligned) begin
      load_value = 32'd0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs.  A read always passes through WAIT:
  // the first WAIT cycle is the RAM read slot and the remaining WAIT_STATES
  // cycles are the configurable extra latency, so data is valid at edge
  // accept+1+WAIT_STATES.
  always_comb begin
    state_next = state;
    req_sync   = 1'b0;
    resp_sync  = 1'b0;
    case (state)
      IDLE: begin
        req_sync = 1'b1;
        if (req_notify && !req_req) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_sync = 1'b1;
        if (resp_notify) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: read capture, wait counter, response data and the sticky
  // misalignment flag.  Load data is registered on entry to RESP so it
  // stays stable for however long the core holds off resp_notify.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt        <= 4'd0;
      cap_word        <= '0;
      cap_lane        <= 2'd0;
      cap_mask        <= 3'd0;
      cap_misaligned  <= 1'b0;
      resp_loadeddata <= 32'd0;
      misalign_err    <= 1'b0;
    end else begin
      if (accept && req_misaligned) begin
        misalign_err <= 1'b1;
      end
      if (accept && !req_req) begin
        cap_word       <= req_word;
        cap_lane       <= req_lane;
        cap_mask       <= req_mask;
        cap_misaligned <= req_misaligned;
        wait_cnt       <= 4'd0;
      end else if (state == WAIT) begin
        if (wait_cnt == WAIT_LAST) begin
          resp_loadeddata <= load_value;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
    end
  end

endmodule
